// File: rtl/symb_packer_pkg.sv
// Shared constants, FSM state type and qam saturation helper for the symbol packer.
package symb_packer_pkg;

    localparam int cQAM_MAX = 10;
    localparam int cDAT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // A qam of 0 would never emit, so it is promoted to 1; anything wider than the mapper is clipped.
    function automatic logic [3:0] sat_qam(input logic [3:0] q);
        if (q == 4'd0) begin
            return 4'd1;
        end else if (q > 4'(cQAM_MAX)) begin
            return 4'(cQAM_MAX);
        end
        return q;
    endfunction

endpackage

// File: rtl/symb_packer_if.sv
// Byte-in / symbol-out bus of the symbol packer.
// Handshake: a byte transfers on a clock edge where ival & ordy are both high (and the block is
// clock-enabled); the output side has no ready, each oval pulse is one symbol the sink must take.
interface symb_packer_if #(
    parameter int pDAT_W = 8,
    parameter int pSYM_W = 10
);
    logic              isop;
    logic              ival;
    logic              ieop;
    logic [3:0]        iqam;
    logic [pDAT_W-1:0] idat;
    logic              ordy;
    logic              osop;
    logic              oval;
    logic              oeop;
    logic [3:0]        oqam;
    logic [pSYM_W-1:0] odat;

    modport master (
        output isop, ival, ieop, iqam, idat,
        input  ordy, osop, oval, oeop, oqam, odat
    );

    modport slave (
        input  isop, ival, ieop, iqam, idat,
        output ordy, osop, oval, oeop, oqam, odat
    );
endinterface

// File: rtl/symb_packer.sv
// Repacks a framed byte stream into qam-bit symbols, LSB first, with a bit accumulator.
// FSM state is exported on ostate for observation.
module symb_packer
    import symb_packer_pkg::*;
#(
    parameter int pDAT_W = cDAT_W,
    parameter int pSYM_W = cQAM_MAX,
    parameter int pACC_W = 18
) (
    input  logic           iclk,
    input  logic           ireset,
    input  logic           iclkena,
    symb_packer_if.slave   bus,
    output state_t         ostate
);

    localparam int cCNT_W = $clog2(pACC_W + 1);

    state_t              r_state;
    logic [pACC_W-1:0]   r_acc;
    logic [cCNT_W-1:0]   r_cnt;
    logic [3:0]          r_qam;
    logic                r_sop_pend;
    logic                r_osop;
    logic                r_oval;
    logic                r_oeop;
    logic [pSYM_W-1:0]   r_odat;

    logic [cCNT_W-1:0]   w_qam;
    logic                w_emit;
    logic [pACC_W-1:0]   w_acc_sh;
    logic [cCNT_W-1:0]   w_cnt_sh;
    logic                w_ordy;
    logic                w_accept;
    logic                w_start;
    logic                w_take;
    logic                w_last;
    logic [pACC_W-1:0]   w_byte;
    logic [pSYM_W-1:0]   w_mask;
    logic [pSYM_W-1:0]   w_sym;
    state_t              w_state_nxt;
    logic [pACC_W-1:0]   w_acc_nxt;
    logic [cCNT_W-1:0]   w_cnt_nxt;

    assign w_qam    = cCNT_W'(r_qam);
    assign w_emit   = ((r_state == RUN) && (r_cnt >= w_qam)) ||
                      ((r_state == FLUSH) && (r_cnt != '0));
    assign w_acc_sh = w_emit ? (r_acc >> r_qam) : r_acc;
    // A short final symbol in FLUSH is zero padded, so the count saturates at 0.
    assign w_cnt_sh = w_emit ? ((r_cnt > w_qam) ? (r_cnt - w_qam) : '0) : r_cnt;

    assign w_ordy   = (r_state != FLUSH) && (w_cnt_sh <= cCNT_W'(pACC_W - pDAT_W));
    assign w_accept = bus.ival && w_ordy;
    assign w_start  = w_accept && bus.isop;
    assign w_take   = w_accept && !bus.isop && (r_state == RUN);
    assign w_last   = w_emit && (r_state == FLUSH) && (w_cnt_sh == '0);
    assign w_byte   = {{(pACC_W - pDAT_W){1'b0}}, bus.idat};

    assign w_mask   = {pSYM_W{1'b1}} >> (pSYM_W - int'(r_qam));
    assign w_sym    = r_acc[pSYM_W-1:0] & w_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = w_acc_sh;
        w_cnt_nxt   = w_cnt_sh;
        if (w_start) begin
            // A sop restarts the accumulator, which also aborts any frame in progress.
            w_acc_nxt   = w_byte;
            w_cnt_nxt   = cCNT_W'(pDAT_W);
            w_state_nxt = bus.ieop ? FLUSH : RUN;
        end else if (w_take) begin
            w_acc_nxt = w_acc_sh | (w_byte << w_cnt_sh);
            w_cnt_nxt = w_cnt_sh + cCNT_W'(pDAT_W);
            if (bus.ieop) begin
                w_state_nxt = FLUSH;
            end
        end else if (w_last) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_qam      <= '0;
            r_sop_pend <= 1'b0;
            r_osop     <= 1'b0;
            r_oval     <= 1'b0;
            r_oeop     <= 1'b0;
            r_odat     <= '0;
        end else if (iclkena) begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_oval     <= w_emit;
            if (w_start) begin
                r_qam <= sat_qam(bus.iqam);
            end
            // A symbol emitted in the same cycle as a new sop still belongs to the old frame.
            r_sop_pend <= w_start || (r_sop_pend && !w_emit);
            if (w_emit) begin
                r_odat <= w_sym;
                r_osop <= r_sop_pend;
                r_oeop <= w_last;
            end else begin
                r_osop <= 1'b0;
                r_oeop <= 1'b0;
            end
        end
    end

    assign bus.ordy = w_ordy;
    assign bus.osop = r_osop;
    assign bus.oval = r_oval;
    assign bus.oeop = r_oeop;
    assign bus.oqam = r_qam;
    assign bus.odat = r_odat;
    assign ostate   = r_state;

endmodule

// File: tb/tb_symb_packer.sv
// Self-checking bench for symb_packer: a bit-level model queues expected symbols per frame,
// a negedge monitor pops and compares them, and scenario tasks add their own direct checks.
module tb_symb_packer;
    import symb_packer_pkg::*;

    logic   iclk = 1'b0;
    logic   ireset;
    logic   iclkena;
    state_t ostate;

    always #5 iclk = ~iclk;

    symb_packer_if bus();

    symb_packer dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .bus     (bus),
        .ostate  (ostate)
    );

    int          checks = 0;
    int          errors = 0;
    int          stall_cnt = 0;
    int          cyc = 0;
    logic        en_edge = 1'b0;
    logic        mon_off = 1'b0;
    logic [15:0] exp_q[$];
    logic [9:0]  obs_q[$];
    int          obs_cyc[$];
    logic [7:0]  tx_bytes[$];

    always @(posedge iclk) begin
        cyc     <= cyc + 1;
        en_edge <= iclkena;
    end

    // ---------------- scoreboard monitor ----------------
    logic [15:0] got;
    logic [15:0] exp_v;
    always @(negedge iclk) begin
        if (!ireset && en_edge && !mon_off && bus.oval) begin
            got = {bus.oqam, bus.osop, bus.oeop, bus.odat};
            obs_q.push_back(bus.odat);
            obs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_symbol got qam=%0d sop=%b eop=%b dat=%h, expected none",
                         got[15:12], got[11], got[10], got[9:0]);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL symbol got qam=%0d sop=%b eop=%b dat=%h, expected qam=%0d sop=%b eop=%b dat=%h",
                             got[15:12], got[11], got[10], got[9:0],
                             exp_v[15:12], exp_v[11], exp_v[10], exp_v[9:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- model and drivers ----------------
    task automatic push_expect(input logic [3:0] qam);
        int qs;
        int total;
        logic [3:0] q4;
        qs    = (qam == 4'd0) ? 1 : ((qam > 4'd10) ? 10 : int'(qam));
        q4    = 4'(qs);
        total = 8 * tx_bytes.size();
        for (int pos = 0; pos < total; pos += qs) begin
            logic [9:0] s;
            logic [7:0] by;
            s = '0;
            for (int b = 0; b < qs; b++) begin
                if (pos + b < total) begin
                    by   = tx_bytes[(pos + b) / 8];
                    s[b] = by[(pos + b) % 8];
                end
            end
            exp_q.push_back({q4, (pos == 0), (pos + qs >= total), s});
        end
    endtask

    task automatic send_byte(input logic sop, input logic eop, input logic [3:0] qam,
                             input logic [7:0] dat);
        bus.isop = sop;
        bus.ieop = eop;
        bus.iqam = qam;
        bus.idat = dat;
        bus.ival = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge iclk);
            if (bus.ordy && iclkena) begin
                @(posedge iclk);
                #1;
                bus.ival = 1'b0;
                bus.isop = 1'b0;
                bus.ieop = 1'b0;
                return;
            end
            if (iclkena) stall_cnt++;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout got no accept for byte %h, expected accept within 1000 cycles", dat);
        bus.ival = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] qam);
        push_expect(qam);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            send_byte(i == 0, i == tx_bytes.size() - 1, qam, tx_bytes[i]);
        end
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge iclk);
        repeat (3) @(posedge iclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d symbols outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (ostate !== IDLE || bus.ordy !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_%s got state=%0d ordy=%b, expected state=0 ordy=1",
                     name, ostate, bus.ordy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ireset   = 1'b1;
        iclkena  = 1'b1;
        bus.ival = 1'b0;
        bus.isop = 1'b0;
        bus.ieop = 1'b0;
        bus.iqam = 4'd0;
        bus.idat = 8'h00;
        repeat (3) @(posedge iclk);
        #1;
        checks++;
        if ({bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got sop=%b val=%b eop=%b qam=%0d dat=%h, expected all 0",
                     bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat);
        end
        checks++;
        if (bus.ordy !== 1'b1 || ostate !== IDLE) begin
            errors++;
            $display("FAIL reset_ordy got ordy=%b state=%0d, expected ordy=1 state=0", bus.ordy, ostate);
        end
        @(negedge iclk);
        ireset = 1'b0;
        @(posedge iclk);
        #1;
    endtask

    task automatic test_qam2_single();
        logic [9:0] want [4] = '{10'd0, 10'd1, 10'd3, 10'd2};
        obs_q.delete();
        obs_cyc.delete();
        tx_bytes = '{8'hB4};
        send_frame(4'd2);
        drain("qam2");
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL qam2_count got %0d symbols, expected 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL qam2_sym%0d got %h, expected %h", i, obs_q[i], want[i]);
                end
            end
            checks++;
            if (obs_cyc[3] - obs_cyc[0] != 3) begin
                errors++;
                $display("FAIL qam2_consecutive got span %0d cycles, expected 3", obs_cyc[3] - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_qam3_pad();
        obs_q.delete();
        tx_bytes = '{8'hFF};
        push_expect(4'd3);
        send_byte(1'b1, 1'b1, 4'd3, 8'hFF);
        checks++;
        if (bus.ordy !== 1'b0 || ostate !== FLUSH) begin
            errors++;
            $display("FAIL qam3_flush_entry got ordy=%b state=%0d, expected ordy=0 state=2", bus.ordy, ostate);
        end
        @(posedge iclk);
        #1;
        checks++;
        if (bus.ordy !== 1'b0) begin
            errors++;
            $display("FAIL qam3_flush_ordy got %b, expected 0", bus.ordy);
        end
        drain("qam3");
        checks++;
        if (obs_q.size() != 3 || obs_q[0] !== 10'd7 || obs_q[1] !== 10'd7 || obs_q[2] !== 10'd3) begin
            errors++;
            $display("FAIL qam3_values got %0d symbols, expected 7,7,3", obs_q.size());
        end
    endtask

    task automatic test_qam10();
        obs_q.delete();
        tx_bytes = '{8'h34, 8'h12};
        send_frame(4'd10);
        drain("qam10");
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 10'h234 || obs_q[1] !== 10'h004) begin
            errors++;
            $display("FAIL qam10_values got %0d symbols first=%h, expected 234,004",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h3ff);
        end
    endtask

    task automatic test_qam8_stream();
        obs_q.delete();
        obs_cyc.delete();
        tx_bytes.delete();
        for (int i = 0; i < 256; i++) tx_bytes.push_back(8'(i));
        stall_cnt = 0;
        send_frame(4'd8);
        checks++;
        if (stall_cnt != 0) begin
            errors++;
            $display("FAIL qam8_ordy got %0d stall cycles, expected 0", stall_cnt);
        end
        drain("qam8");
        checks++;
        if (obs_q.size() != 256 || obs_cyc[255] - obs_cyc[0] != 255) begin
            errors++;
            $display("FAIL qam8_stream got %0d symbols, expected 256 on consecutive cycles", obs_q.size());
        end
    endtask

    task automatic test_qam1_backpressure();
        obs_q.delete();
        tx_bytes.delete();
        for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        stall_cnt = 0;
        send_frame(4'd1);
        checks++;
        if (stall_cnt == 0) begin
            errors++;
            $display("FAIL qam1_backpressure got 0 stall cycles, expected ordy to deassert");
        end
        drain("qam1");
        checks++;
        if (obs_q.size() != 32) begin
            errors++;
            $display("FAIL qam1_count got %0d symbols, expected 32", obs_q.size());
        end
    endtask

    task automatic test_misc_qams();
        logic [3:0] qams [7] = '{4'd5, 4'd6, 4'd7, 4'd0, 4'd15, 4'd4, 4'd9};
        for (int k = 0; k < 7; k++) begin
            tx_bytes.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            send_frame(qams[k]);
            drain("misc");
        end
    endtask

    task automatic test_idle_discard();
        send_byte(1'b0, 1'b0, 4'd4, 8'hA5);
        send_byte(1'b0, 1'b1, 4'd4, 8'h5A);
        repeat (4) @(posedge iclk);
        #1;
        checks++;
        if (ostate !== IDLE) begin
            errors++;
            $display("FAIL idle_discard got state=%0d, expected 0", ostate);
        end
    endtask

    task automatic test_clkena_freeze();
        tx_bytes.delete();
        for (int i = 0; i < 8; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        fork
            send_frame(4'd3);
            begin
                logic [17:0] snap;
                state_t      snap_st;
                repeat (6) @(posedge iclk);
                #2;
                snap    = {bus.ordy, bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat};
                snap_st = ostate;
                iclkena = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge iclk);
                    checks++;
                    if ({bus.ordy, bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat} !== snap ||
                        ostate !== snap_st) begin
                        errors++;
                        $display("FAIL clkena_freeze cycle %0d got %h state=%0d, expected %h state=%0d",
                                 c, {bus.ordy, bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat},
                                 ostate, snap, snap_st);
                    end
                end
                @(posedge iclk);
                #2;
                iclkena = 1'b1;
            end
        join
        drain("clkena");
    endtask

    task automatic test_async_reset();
        mon_off = 1'b1;
        send_byte(1'b1, 1'b0, 4'd2, 8'hFF);
        send_byte(1'b0, 1'b0, 4'd2, 8'hC3);
        send_byte(1'b0, 1'b0, 4'd2, 8'h5A);
        checks++;
        if (bus.oqam !== 4'd2 || ostate !== RUN) begin
            errors++;
            $display("FAIL pre_reset got qam=%0d state=%0d, expected qam=2 state=1", bus.oqam, ostate);
        end
        #2;
        ireset = 1'b1;
        #1;
        checks++;
        if ({bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat} !== 17'd0 || ostate !== IDLE ||
            bus.ordy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got sop=%b val=%b eop=%b qam=%0d dat=%h state=%0d ordy=%b, expected zeros idle ordy=1",
                     bus.osop, bus.oval, bus.oeop, bus.oqam, bus.odat, ostate, bus.ordy);
        end
        @(negedge iclk);
        ireset = 1'b0;
        @(posedge iclk);
        #1;
        mon_off = 1'b0;
        tx_bytes = '{8'h81, 8'h7E, 8'h3C};
        send_frame(4'd6);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_qam2_single();
        test_qam3_pad();
        test_qam10();
        test_qam8_stream();
        test_qam1_backpressure();
        test_misc_qams();
        test_idle_discard();
        test_clkena_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/symb_packer.md
Name: symb_packer

Overview:
- Transmit-side front end; the counterpart to the demapper's bit recovery.
- Takes a framed byte stream and repacks it into qam-bit symbol words for gray_bit_mapper.
- Symbol format matches what the demapper hard-decides back: symbol bit i = LLR index i, LSB first.
- Sits between the payload source and gray_bit_mapper. Applies backpressure to the source via ordy.

Parameters:
pDAT_W, 8, input byte width in bits
pSYM_W, 10, max symbol width in bits (qam up to 10)
pACC_W, 18, bit accumulator width; must be >= pDAT_W + pSYM_W

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active-high
iclkena  in  1  clock enable; when low, all state holds
isop  in  1  first byte of frame; qualified by ival
ival  in  1  input byte valid
ieop  in  1  last byte of frame; qualified by ival
iqam  in  4  bits per symbol; sampled with isop
idat  in  pDAT_W  input byte
ordy  out  1  block can accept a byte this cycle
osop  out  1  first symbol of frame
oval  out  1  symbol valid
oeop  out  1  last symbol of frame
oqam  out  4  frame qam, held for the whole frame
odat  out  pSYM_W  symbol bits, LSB = first bit; bits >= oqam are 0

Behaviour:
- Reset (async, ireset=1): state=IDLE, acc=0, cnt=0; osop=oval=oeop=0, oqam=0, odat=0. ordy=1 after reset.
- Clock enable: all updates gated by iclkena. ordy is combinational from registers, valid regardless of iclkena.
- Byte accept: accept = ival & ordy. ival while ordy=0 is ignored (the byte is dropped); the source must honour ordy.
- States:
  - IDLE: waits for accept & isop.
  - RUN: accepts bytes; emits symbols.
  - FLUSH: entered on accept of the ieop byte; no accepts; drains remaining bits.
  - FLUSH -> IDLE after the oeop symbol is emitted.
  - isop & ieop on the same byte is a one-byte frame: go straight to FLUSH.
- qam latch: on accept & isop, qam_r = iqam. iqam=0 is treated as 1; iqam>10 is treated as 10. oqam = qam_r.
- Accumulator:
  - A new byte is appended at bit position cnt (LSB first; byte bit 0 lands in the earliest symbol).
  - On emit: odat = acc[qam_r-1:0] with upper bits zeroed, acc >>= qam_r, cnt -= qam_r.
  - Accept and emit can happen in the same cycle: cnt_next = cnt - emit*qam_r + accept*pDAT_W.
- Emit rules:
  - RUN: emit when cnt >= qam_r.
  - FLUSH: emit when cnt > 0. If cnt < qam_r, pad with zeros and set cnt to 0.
  - oeop=1 on the emit that brings cnt to 0 in FLUSH.
  - osop=1 on the first emit after the isop accept.
  - osop and oeop may both be 1 for a single-symbol frame.
- ordy = (state != FLUSH) & ((cnt - (emit_now ? qam_r : 0)) <= pACC_W - pDAT_W).
  - For qam >= 8, ordy stays continuously 1 in RUN.
- Outputs are registered. A symbol appears on odat/oval one cycle after the cycle in which its last bit was accepted.
- oval is a single-cycle pulse per symbol. It is 0 in any cycle with no emit; odat holds its last value in those cycles.
- Abort: accept & isop while in RUN clears acc and cnt and starts a new frame with the new qam. The old frame gets no oeop.
- isop without ival has no effect. In IDLE, bytes accepted without isop are discarded.
- Reset mid-frame: all state is cleared immediately; no oeop is produced.

Decomposition:
- Package symb_packer_pkg holds: cQAM_MAX=10, cDAT_W=8, the qam saturation function, and the state enum (IDLE, RUN, FLUSH).
- No sub-module. The accumulator, counter and FSM fit in a single module of roughly 150-250 lines.

Test Plan:
- qam=2, single byte 0xB4 with isop=ieop=1 -> odat 0,1,3,2 on four consecutive cycles; osop on the first, oeop on the last.
- qam=3, byte 0xFF with sop+eop -> odat 7,7,3 (last padded); oeop on the third; ordy=0 during FLUSH, 1 afterwards.
- qam=10, bytes 0x34 (sop) then 0x12 (eop) -> odat 0x234 then 0x004 (eop).
- qam=8, 256 back-to-back bytes 0..255 -> ordy stays 1; odat == idat one cycle after each accept; eop on symbol 255.
- qam=1, back-to-back bytes -> ordy deasserts; 8 symbols are emitted per byte; bit stream matches LSB-first order. Also run qam=5, 6, 7 in loopback through gray_bit_mapper/mapper/demapper: hard decisions equal the symbols.
- Reset and enables:
  - Async reset asserted mid-frame -> all outputs go to 0 with no clock edge.
  - A new sop afterwards starts a clean frame.
  - iclkena=0 for 5 cycles mid-frame -> outputs and state frozen, no symbols lost.
